// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, result selection, register file write port,
// same-cycle WB->ID bypass and a retired-instruction counter.
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_w,
    input  logic             flush_w,
    input  logic             valid_m,
    input  logic             RegWrite_m,
    input  logic [1:0]       ResultSrc_m,
    input  logic [2:0]       funct3_m,
    input  logic [XLEN-1:0]  ALUResult_m,
    input  logic [XLEN-1:0]  ReadData_m,
    input  logic [XLEN-1:0]  PCPlus4_m,
    input  logic [4:0]       Rd_m,
    input  logic [4:0]       A1_d,
    input  logic [4:0]       A2_d,
    input  logic [XLEN-1:0]  RD1_rf,
    input  logic [XLEN-1:0]  RD2_rf,
    output logic [4:0]       A3,
    output logic [XLEN-1:0]  WD3,
    output logic             WE3,
    output logic [XLEN-1:0]  RD1_d,
    output logic [XLEN-1:0]  RD2_d,
    output logic             valid_w,
    output logic [CNT_W-1:0] instret
);

    logic             valid_q,     valid_d;
    logic             regwrite_q,  regwrite_d;
    logic [1:0]       resultsrc_q, resultsrc_d;
    logic [2:0]       funct3_q,    funct3_d;
    logic [XLEN-1:0]  aluresult_q, aluresult_d;
    logic [XLEN-1:0]  readdata_q,  readdata_d;
    logic [XLEN-1:0]  pcplus4_q,   pcplus4_d;
    logic [4:0]       rd_q,        rd_d;
    logic [CNT_W-1:0] instret_q,   instret_d;

    logic [XLEN-1:0]  load_val_s;
    logic [XLEN-1:0]  wd3_s;
    logic             we3_s;

    // Picks the addressed byte/halfword out of the aligned word and extends it.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] data
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = data[{off, 3'b000} +: 8];
        half_v = data[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_extract = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b001:  load_extract = {{(XLEN-16){half_v[15]}}, half_v};
            3'b100:  load_extract = {{(XLEN-8){1'b0}}, byte_v};
            3'b101:  load_extract = {{(XLEN-16){1'b0}}, half_v};
            default: load_extract = data;
        endcase
    endfunction

    // Next-state: flush beats stall beats capture; retirement is independent of flush.
    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        resultsrc_d = resultsrc_q;
        funct3_d    = funct3_q;
        aluresult_d = aluresult_q;
        readdata_d  = readdata_q;
        pcplus4_d   = pcplus4_q;
        rd_d        = rd_q;
        instret_d   = instret_q;

        if (valid_q && !stall_w) begin
            instret_d = instret_q + CNT_W'(1);
        end else begin
            instret_d = instret_q;
        end

        if (flush_w) begin
            valid_d = 1'b0;
        end else if (stall_w) begin
            valid_d = valid_q;
        end else begin
            valid_d     = valid_m;
            regwrite_d  = RegWrite_m;
            resultsrc_d = ResultSrc_m;
            funct3_d    = funct3_m;
            aluresult_d = ALUResult_m;
            readdata_d  = ReadData_m;
            pcplus4_d   = PCPlus4_m;
            rd_d        = Rd_m;
        end
    end

    // WB pipeline register and retirement counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            funct3_q    <= 3'b000;
            aluresult_q <= '0;
            readdata_q  <= '0;
            pcplus4_q   <= '0;
            rd_q        <= 5'd0;
            instret_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            funct3_q    <= funct3_d;
            aluresult_q <= aluresult_d;
            readdata_q  <= readdata_d;
            pcplus4_q   <= pcplus4_d;
            rd_q        <= rd_d;
            instret_q   <= instret_d;
        end
    end

    // Writeback result selection; the reserved encoding falls back to the ALU result.
    always_comb begin
        load_val_s = load_extract(funct3_q, aluresult_q[1:0], readdata_q);
        case (resultsrc_q)
            2'b01:   wd3_s = load_val_s;
            2'b10:   wd3_s = pcplus4_q;
            default: wd3_s = aluresult_q;
        endcase
        we3_s = valid_q & regwrite_q & (rd_q != 5'd0);
    end

    // Bypass covers the register file's edge-only write, so decode sees WB data in the same cycle.
    always_comb begin
        if (we3_s && (rd_q == A1_d) && (A1_d != 5'd0)) begin
            RD1_d = wd3_s;
        end else begin
            RD1_d = RD1_rf;
        end
        if (we3_s && (rd_q == A2_d) && (A2_d != 5'd0)) begin
            RD2_d = wd3_s;
        end else begin
            RD2_d = RD2_rf;
        end
    end

    assign A3      = rd_q;
    assign WD3     = wd3_s;
    assign WE3     = we3_s;
    assign valid_w = valid_q;
    assign instret = instret_q;

endmodule
